fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 14 +
 rtl/fetch_buffer.sv | 64 ++++++
 rtl/fetch_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants.
// Imported by fetch_unit and fetch_buffer.
package riscv_pkg;

    typedef enum logic [1:0] {
        HOLD,
        RUN,
        FLUSH
    } fetch_state_t;

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h4000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {pc, inst} FIFO between fetch and decode.
// An empty head presents pc=0 and a NOP.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [AWIDTH-1:0] push_pc,
    input  logic [31:0]       push_inst,
    output logic [AWIDTH-1:0] head_pc,
    output logic [31:0]       head_inst,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count
);

    logic [AWIDTH-1:0] pc_q   [2];
    logic [31:0]       inst_q [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    // Push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= NOP_INST;
            end
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                pc_q[wr_ptr]   <= push_pc;
                inst_q[wr_ptr] <= push_inst;
                wr_ptr         <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head_pc   = empty ? '0 : pc_q[rd_ptr];
    assign head_inst = empty ? NOP_INST : inst_q[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC, redirect flush, 2-entry output buffer.
// Define FETCH_MISALIGN_CHECK_EN to add the sticky misalign flag.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int                AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [AWIDTH-1:0] imem_addr,
    output logic              imem_en,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [AWIDTH-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AWIDTH-1:0] out_pc,
    output logic [31:0]       out_inst
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic              misalign
`endif
);

    fetch_state_t      state;
    logic [AWIDTH-1:0] pc;
    logic [AWIDTH-1:0] pend_pc;
    logic [AWIDTH-1:0] tgt;
    logic              pend;
    logic              pend_run;
    logic              live;
    logic              take;
    logic              stop;
    logic              room;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [1:0]        count;

    assign live = (state != HOLD);
    assign take = redirect && live;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic bad;
    assign bad  = take && (redirect_pc[1:0] != 2'b00);
    assign tgt  = redirect_pc;
    assign stop = misalign;
`else
    assign tgt  = redirect_pc & ~AWIDTH'(3);
    assign stop = 1'b0;
`endif

    // A response only counts toward occupancy when it will be kept.
    assign pend_run = pend && (state == RUN);
    assign pop      = out_ready && !empty;
    assign push     = pend_run && !take;

    always_comb begin
        room = 1'b0;
        if (pop) begin
            room = !full || !pend_run;
        end else begin
            room = ({1'b0, count} + {2'b00, pend_run}) < 3'd2;
        end
    end

    assign imem_en   = live && !stop && room;
    assign imem_addr = pc;
    assign out_valid = !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= HOLD;
            pc      <= RESET_PC;
            pend    <= 1'b0;
            pend_pc <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign <= 1'b0;
`endif
        end else begin
            pend <= imem_en;
            if (imem_en) begin
                pend_pc <= pc;
            end
            case (state)
                HOLD:       state <= RUN;
                RUN, FLUSH: state <= (take && imem_en) ? FLUSH : RUN;
                default:    state <= HOLD;
            endcase
            if (take) begin
                pc <= tgt;
            end else if (imem_en) begin
                pc <= pc + AWIDTH'(4);
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            if (bad) begin
                misalign <= 1'b1;
            end
`endif
        end
    end

    fetch_buffer #(
        .AWIDTH(AWIDTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (take),
        .push_pc  (pend_pc),
        .push_inst(imem_rdata),
        .head_pc  (out_pc),
        .head_inst(out_inst),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

endmodule
